// File: rtl/regfile_dump.sv
// regfile_dump: sweeps a wrap-around range of registers through one
// asynchronous register-file read port and streams each captured word out
// on a valid/ready interface, tagged with its register number.
module regfile_dump #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] end_addr_d;
    logic              capture;

    // State and sweep-range registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            end_addr <= '0;
        end else begin
            state    <= state_d;
            addr     <= addr_d;
            end_addr <= end_addr_d;
        end
    end

    // Next-state logic; abort beats a simultaneous handshake
    always_comb begin
        state_d    = state;
        addr_d     = addr;
        end_addr_d = end_addr;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_d     = first;
                    end_addr_d = last;
                    state_d    = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (addr == end_addr) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = ADDR_W'(addr + 1'b1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_ra     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            busy      <= (state_d == READ) || (state_d == HOLD);
            done      <= (state_d == DONE);
            out_valid <= (state_d == HOLD);
            rf_ra     <= ((state_d == READ) || (state_d == HOLD)) ? addr_d : '0;
            if (capture) begin
                out_data <= rf_rd;
                out_addr <= addr;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a register-file model plus a queue of expected
// words built from the range rule, checked every cycle by one compare process.
module tb_regfile_dump;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  first;
    logic [4:0]  last;
    logic        busy;
    logic        done;
    logic [4:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;

    logic [31:0] regs [32];
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    int vec_cnt;
    int err_cnt;

    logic [4:0]  exp_a [$];
    logic [31:0] exp_d [$];
    bit          done_ok;
    bit          in_rst;

    int          got_n;
    logic [4:0]  got_a [64];
    logic [31:0] got_d [64];
    int          got_c [64];
    int          done_cyc;

    regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .first     (first),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .rf_ra     (rf_ra),
        .rf_rd     (rf_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: single write port, register 0 hard-wired to zero
    always @(posedge clk) begin
        if (we) regs[wa] <= wd;
    end
    assign rf_rd = (rf_ra == 5'd0) ? 32'd0 : regs[rf_ra];

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        vec_cnt++;
        if (got !== expv) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, got, expv, $time);
        end
    endfunction

    // Compare process: every presented word must be the model's next word
    always @(negedge clk) begin
        if (!in_rst) begin
            if (out_valid) begin
                if (exp_a.size() == 0) begin
                    chk("unexpected_word", 32'(out_addr), 32'hFFFF_FFFF);
                end else begin
                    chk("word_addr", 32'(out_addr), 32'(exp_a[0]));
                    chk("word_data", out_data, exp_d[0]);
                    chk("rf_ra_hold", 32'(rf_ra), 32'(out_addr));
                    if (out_ready && !abort) begin
                        void'(exp_a.pop_front());
                        void'(exp_d.pop_front());
                    end
                end
            end
            if (done) begin
                chk("done_allowed", 32'(done_ok), 32'd1);
                chk("done_drained", 32'(exp_a.size()), 32'd0);
            end
        end
    end

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        we = 1'b1; wa = a; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    // One sweep; cycle c counts from the edge that samples start (edge 0)
    task automatic sweep(input logic [4:0] f, input logic [4:0] l, input int stall_w,
                         input int stall_n, input int abort_w, input int conc_a,
                         input bit start_in_done);
        int   n;
        int   c;
        int   stalled;
        bit   fin;
        bit   ab;
        logic [4:0] a;
        n = int'(5'(l - f)) + 1;
        for (int i = 0; i < n; i++) begin
            a = 5'(f + 5'(i));
            exp_a.push_back(a);
            exp_d.push_back((a == 5'd0) ? 32'd0 : regs[a]);
        end
        done_ok  = (abort_w < 0);
        got_n    = 0;
        done_cyc = -1;
        stalled  = 0;
        fin      = 1'b0;
        ab       = 1'b0;
        @(posedge clk); #1;
        first = f; last = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (!fin && c < 400) begin
            we = 1'b0; abort = 1'b0; out_ready = 1'b1;
            if (out_valid && got_n == stall_w && stalled < stall_n) begin
                out_ready = 1'b0;
                stalled++;
            end
            if (out_valid && got_n == abort_w) abort = 1'b1;
            if (conc_a >= 0 && busy && !out_valid && rf_ra == 5'(conc_a)) begin
                we = 1'b1; wa = 5'(conc_a); wd = 32'h0000_1234;
            end
            @(negedge clk);
            if (ab) begin
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                fin = 1'b1;
            end else if (done) begin
                done_cyc = c;
                chk("busy_in_done", 32'(busy), 32'd0);
                fin = 1'b1;
                if (start_in_done) start = 1'b1;
            end else begin
                chk("busy_in_sweep", 32'(busy), 32'd1);
            end
            if (out_valid && out_ready && !abort) begin
                got_a[got_n] = out_addr;
                got_d[got_n] = out_data;
                got_c[got_n] = c;
                got_n++;
            end
            if (abort) ab = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        we = 1'b0; abort = 1'b0; start = 1'b0;
        if (!fin) chk("sweep_timeout", 32'(c), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
        exp_a.delete();
        exp_d.delete();
        done_ok = 1'b0;
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; first = '0; last = '0;
        out_ready = 1'b1; we = 1'b0; wa = '0; wd = '0;
        done_ok = 1'b0; in_rst = 1'b1;
        got_n = 0; done_cyc = -1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_ra", 32'(rf_ra), 32'd0);
        rst_n = 1'b1; in_rst = 1'b0;

        for (int i = 0; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h0101_0101);

        // Full sweep 0..31
        sweep(5'd0, 5'd31, -1, 0, -1, -1, 1'b0);
        chk("full_count", 32'(got_n), 32'd32);
        chk("full_done_cyc", 32'(done_cyc), 32'd65);
        chk("full_reg0", got_d[0], 32'd0);
        chk("full_reg31", got_d[31], 32'h1F1F_1F1F);
        chk("full_addr17", 32'(got_a[17]), 32'd17);

        // Single register, with a start in the DONE cycle that must be ignored
        write_reg(5'd5, 32'hDEAD_BEEF);
        sweep(5'd5, 5'd5, -1, 0, -1, -1, 1'b1);
        chk("single_count", 32'(got_n), 32'd1);
        chk("single_addr", 32'(got_a[0]), 32'd5);
        chk("single_data", got_d[0], 32'hDEAD_BEEF);
        chk("single_word_cyc", 32'(got_c[0]), 32'd2);
        chk("single_done_cyc", 32'(done_cyc), 32'd3);

        // Wrap-around 30..1
        sweep(5'd30, 5'd1, -1, 0, -1, -1, 1'b0);
        chk("wrap_count", 32'(got_n), 32'd4);
        chk("wrap_a0", 32'(got_a[0]), 32'd30);
        chk("wrap_a1", 32'(got_a[1]), 32'd31);
        chk("wrap_a2", 32'(got_a[2]), 32'd0);
        chk("wrap_a3", 32'(got_a[3]), 32'd1);
        chk("wrap_done_cyc", 32'(done_cyc), 32'd9);

        // Backpressure: 5 stall cycles on the second word
        sweep(5'd10, 5'd13, 1, 5, -1, -1, 1'b0);
        chk("bp_count", 32'(got_n), 32'd4);
        chk("bp_word1_cyc", 32'(got_c[1]), 32'd9);
        chk("bp_done_cyc", 32'(done_cyc), 32'd14);

        // Abort in the HOLD of word 3 of 8 with out_ready high
        sweep(5'd2, 5'd9, -1, 0, 2, -1, 1'b0);
        chk("abort_count", 32'(got_n), 32'd2);
        chk("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

        // Write to reg 7 on the edge that captures it: old value expected
        sweep(5'd5, 5'd8, -1, 0, -1, 7, 1'b0);
        chk("conc_count", 32'(got_n), 32'd4);
        chk("conc_addr", 32'(got_a[2]), 32'd7);
        chk("conc_old_value", got_d[2], 32'h0707_0707);
        chk("conc_done_cyc", 32'(done_cyc), 32'd9);
        sweep(5'd7, 5'd7, -1, 0, -1, -1, 1'b0);
        chk("conc_new_value", got_d[0], 32'h0000_1234);

        // Reset asserted mid-HOLD
        for (int i = 3; i <= 6; i++) begin
            exp_a.push_back(5'(i));
            exp_d.push_back(regs[i]);
        end
        @(posedge clk); #1;
        first = 5'd3; last = 5'd6; start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0; in_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ra", 32'(rf_ra), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_data", out_data, 32'd0);
        exp_a.delete();
        exp_d.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; in_rst = 1'b0; out_ready = 1'b1;
        sweep(5'd0, 5'd3, -1, 0, -1, -1, 1'b0);
        chk("post_rst_count", 32'(got_n), 32'd4);
        chk("post_rst_done_cyc", 32'(done_cyc), 32'd9);
        chk("post_rst_a3", 32'(got_a[3]), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug/readback engine that sweeps a contiguous, wrap-around range of general-purpose registers through one asynchronous read port of the register file. It streams each captured word out on a valid/ready interface, tagged with its register number. It is the reader counterpart to the write-back path: it sits beside the register file, owns one read-address port, and feeds the debug/trace unit.

## Interface
- ADDR_W, 5, register-number width (32 registers)
- DATA_W, 32, register data width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; sampled only in IDLE
- abort  input  1  cancel the sweep in progress; synchronous
- first  input  ADDR_W  first register of the range; latched on accepted start
- last  input  ADDR_W  last register of the range, inclusive; latched on accepted start
- busy  output  1  high in READ and HOLD
- done  output  1  one-cycle pulse after the last word is accepted
- rf_ra  output  ADDR_W  read address to the register file port
- rf_rd  input  DATA_W  combinational read data returned for rf_ra
- out_valid  output  1  out_data/out_addr hold a word
- out_ready  input  1  consumer accepts the word when high together with out_valid
- out_data  output  DATA_W  captured register value
- out_addr  output  ADDR_W  register number of out_data

## Operation
- States: IDLE, READ, HOLD, DONE.
- **IDLE**
  - On start=1: latch first into addr and last into end_addr, then go to READ.
  - start is ignored in every other state.
- **READ**
  - rf_ra=addr.
  - At the clock edge: out_data<=rf_rd, out_addr<=addr, out_valid<=1, go to HOLD.
- **HOLD**
  - out_valid=1. out_data and out_addr stay stable until accepted.
  - rf_ra keeps the captured address.
  - On out_ready=1: if addr==end_addr, out_valid<=0 and go to DONE. Otherwise addr<=addr+1 (ADDR_W-bit wrap, 31→0), out_valid<=0, and go to READ.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE.
- **Range and wrap**
  - Word count N = ((last-first) mod 2^ADDR_W)+1.
  - first==last gives 1 word.
  - first=30, last=1 gives 30,31,0,1.
  - first=last+1 gives all 32 registers.
- **abort**
  - abort=1 in READ or HOLD: next state is IDLE, out_valid<=0, no done pulse.
  - abort takes priority over a simultaneous out_ready handshake; that word counts as not delivered.
  - abort in IDLE or DONE has no effect; a DONE pulse still completes.
- **Concurrent writes**
  - The captured value is the register content as rf_rd presents it during the READ cycle.
  - A write to the same register on that same clock edge is not seen; the pre-write value is captured.
  - Register 0 reads as 0.
- **IDLE outputs:** rf_ra=0, busy=0, out_valid=0. out_data and out_addr hold their last values.

## Timing
- Reset (asynchronous, rst_n=0) forces: state IDLE, busy=0, done=0, out_valid=0, out_data=0, out_addr=0, rf_ra=0, addr=0, end_addr=0. Release is synchronous to the next clk edge.
- start sampled at edge 0:
  - READ in cycle 1.
  - First word valid in cycle 2.
- With out_ready tied high:
  - word k is valid in cycle 2k+2.
  - done is high in cycle 2N+1.
  - IDLE again in cycle 2N+2.
  - Throughput is one word per 2 cycles.
- Each cycle out_ready is low while out_valid is high adds exactly one cycle.
- start may be asserted in the DONE cycle but is ignored. The earliest restart is start sampled in the first IDLE cycle.
- Reset mid-sweep: outputs reach their reset values immediately, with no done pulse.

## Test plan
- **Reset mid-HOLD:** rst_n low during HOLD with out_valid=1 → out_valid, busy and rf_ra go to 0 asynchronously; no done; after release, start sweeps normally.
- **Single register:** regs[5]=0xDEADBEEF, first=last=5, start, out_ready=1 → one word (addr 5, 0xDEADBEEF) in cycle 2; done in cycle 3; busy high in cycles 1-2 only.
- **Full sweep:** regs[i]=i*0x01010101, first=0, last=31, out_ready=1 → 32 words in ascending order, reg0=0; done in cycle 65.
- **Wrap:** first=30, last=1 → out_addr sequence 30,31,0,1; done after the 4th accept.
- **Backpressure:** out_ready held low 5 cycles on the second word → out_data/out_addr stable throughout, no extra words; done delayed by exactly 5 cycles.
- **Abort and concurrent write:**
  - abort in the HOLD of word 3 of 8 (out_ready=1 same cycle) → next cycle IDLE, out_valid=0, no done.
  - A write of 0x1234 to reg 7 on the edge that ends READ for addr 7 → captured word is the old value.
